// File: rtl/wb_commit_if.sv
// Bundle of execute/load/memory/decode/register-file signals around the writeback commit stage.
// The slave modport is the commit unit; master is whatever drives it.
interface wb_commit_if #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
);
    logic                        ex_valid;
    logic                        ex_ready;
    logic [4:0]                  ex_rd;
    logic [XLEN-1:0]             ex_result;
    logic                        ld_valid;
    logic                        ld_ready;
    logic [4:0]                  ld_rd;
    logic [2:0]                  ld_funct3;
    logic [1:0]                  ld_offset;
    logic                        mem_rsp_valid;
    logic [XLEN-1:0]             mem_rsp_data;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic                        hazard;
    logic                        rf_w_en;
    logic [4:0]                  rf_rd;
    logic [XLEN-1:0]             rf_data_w;
    logic [$clog2(LQ_DEPTH):0]   lq_count;
    logic                        err_orphan;

    modport master (
        output ex_valid, ex_rd, ex_result, ld_valid, ld_rd, ld_funct3, ld_offset,
               mem_rsp_valid, mem_rsp_data, rs1, rs2,
        input  ex_ready, ld_ready, hazard, rf_w_en, rf_rd, rf_data_w, lq_count, err_orphan
    );

    modport slave (
        input  ex_valid, ex_rd, ex_result, ld_valid, ld_rd, ld_funct3, ld_offset,
               mem_rsp_valid, mem_rsp_data, rs1, rs2,
        output ex_ready, ld_ready, hazard, rf_w_en, rf_rd, rf_data_w, lq_count, err_orphan
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback commit: merges ALU results with in-order load responses into one register-file
// write port, with a load tracking queue, one-entry ALU skid and decode hazard detection.
module wb_commit_unit #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_commit_if.slave  bus
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } lq_ent_t;

    lq_ent_t               lq_q [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]   lq_v_q;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  skid_v_q, skid_v_d;
    logic [4:0]            skid_rd_q, skid_rd_d;
    logic [XLEN-1:0]       skid_data_q, skid_data_d;

    logic                  rf_w_en_q, rf_w_en_d;
    logic [4:0]            rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;
    logic                  err_q;

    logic                  lq_full, lq_empty;
    logic                  ex_acc, ld_push, pop, orphan;
    logic                  waw, hz1, hz2;
    lq_ent_t               head;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [XLEN-1:0]       ld_data;

    assign lq_full  = (cnt_q == CW'(LQ_DEPTH));
    assign lq_empty = (cnt_q == '0);
    assign head     = lq_q[rd_ptr_q];

    // Every queued destination is checked: for WAW against the ALU rd, for RAW against decode.
    always_comb begin
        waw = 1'b0;
        hz1 = 1'b0;
        hz2 = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_v_q[i]) begin
                if (lq_q[i].rd == bus.ex_rd) waw = 1'b1;
                if (lq_q[i].rd == bus.rs1)   hz1 = 1'b1;
                if (lq_q[i].rd == bus.rs2)   hz2 = 1'b1;
            end
        end
        if (skid_v_q && skid_rd_q == bus.rs1) hz1 = 1'b1;
        if (skid_v_q && skid_rd_q == bus.rs2) hz2 = 1'b1;
        if (rf_w_en_q && rf_rd_q == bus.rs1)  hz1 = 1'b1;
        if (rf_w_en_q && rf_rd_q == bus.rs2)  hz2 = 1'b1;
    end

    assign bus.ex_ready = !skid_v_q && !rst && !((bus.ex_rd != 5'd0) && waw);
    assign bus.ld_ready = !lq_full && !rst;
    assign bus.hazard   = ((bus.rs1 != 5'd0) && hz1) || ((bus.rs2 != 5'd0) && hz2);

    assign ex_acc  = bus.ex_valid && bus.ex_ready;
    assign ld_push = bus.ld_valid && bus.ld_ready;
    assign pop     = bus.mem_rsp_valid && !lq_empty;
    assign orphan  = bus.mem_rsp_valid && lq_empty;

    assign byte_sel = bus.mem_rsp_data[{head.off, 3'b000} +: 8];
    assign half_sel = bus.mem_rsp_data[{head.off[1], 4'b0000} +: 16];

    always_comb begin
        case (head.f3)
            3'b000:  ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_data = bus.mem_rsp_data;
        endcase
    end

    // Load response beats the skid, which beats a fresh ALU result. The skid is only ever
    // filled when it is empty, since ex_ready already requires that.
    always_comb begin
        rf_w_en_d   = 1'b0;
        rf_rd_d     = 5'd0;
        rf_data_d   = '0;
        skid_v_d    = skid_v_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;
        if (pop) begin
            rf_w_en_d = (head.rd != 5'd0);
            rf_rd_d   = head.rd;
            rf_data_d = ld_data;
            if (ex_acc) begin
                skid_v_d    = 1'b1;
                skid_rd_d   = bus.ex_rd;
                skid_data_d = bus.ex_result;
            end
        end else if (skid_v_q) begin
            rf_w_en_d = (skid_rd_q != 5'd0);
            rf_rd_d   = skid_rd_q;
            rf_data_d = skid_data_q;
            skid_v_d  = 1'b0;
        end else if (ex_acc) begin
            rf_w_en_d = (bus.ex_rd != 5'd0);
            rf_rd_d   = bus.ex_rd;
            rf_data_d = bus.ex_result;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({ld_push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) lq_q[i] <= '0;
            lq_v_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            skid_v_q    <= 1'b0;
            skid_rd_q   <= 5'd0;
            skid_data_q <= '0;
            rf_w_en_q   <= 1'b0;
            rf_rd_q     <= 5'd0;
            rf_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            // Push and pop never touch the same slot: push needs !full, pop needs !empty.
            if (ld_push) begin
                lq_q[wr_ptr_q]   <= '{rd: bus.ld_rd, f3: bus.ld_funct3, off: bus.ld_offset};
                lq_v_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                lq_v_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + AW'(1);
            end
            cnt_q       <= cnt_d;
            skid_v_q    <= skid_v_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            rf_w_en_q   <= rf_w_en_d;
            rf_rd_q     <= rf_rd_d;
            rf_data_q   <= rf_data_d;
            if (orphan) err_q <= 1'b1;
        end
    end

    assign bus.rf_w_en    = rf_w_en_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_data_w  = rf_data_q;
    assign bus.lq_count   = cnt_q;
    assign bus.err_orphan = err_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: queue/skid reference model compared every cycle,
// plus literal expectations from hand-worked examples.
module tb_wb_commit_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk, rst;
    wb_commit_if #(.XLEN(XLEN), .LQ_DEPTH(DEPTH)) bus ();

    wb_commit_unit #(.XLEN(XLEN), .LQ_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned rd;
        int unsigned f3;
        int unsigned off;
    } ld_t;

    ld_t         m_q[$];
    bit          m_skv;
    int unsigned m_skrd, m_skdata;
    bit          m_wen;
    int unsigned m_rd, m_data;
    bit          m_err;
    int          nchk, nfail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned m_ext(int unsigned f3, int unsigned off, int unsigned w);
        int unsigned b, h;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        case (f3)
            0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4:       return b;
            1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            5:       return h;
            default: return w;
        endcase
    endfunction

    function automatic bit pending(int unsigned r);
        if (r == 0) return 0;
        foreach (m_q[i]) if (m_q[i].rd == r) return 1;
        if (m_skv && m_skrd == r) return 1;
        if (m_wen && m_rd == r) return 1;
        return 0;
    endfunction

    function automatic bit m_ex_ready();
        if (rst || m_skv) return 0;
        if (bus.ex_rd != 0) foreach (m_q[i]) if (m_q[i].rd == bus.ex_rd) return 0;
        return 1;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_skv = 0; m_skrd = 0; m_skdata = 0;
        m_wen = 0; m_rd = 0; m_data = 0;
        m_err = 0;
    endtask

    task automatic m_step();
        bit  acc, push;
        ld_t e;
        acc  = bus.ex_valid && m_ex_ready();
        push = bus.ld_valid && (m_q.size() < DEPTH);
        m_wen = 0; m_rd = 0; m_data = 0;
        if (bus.mem_rsp_valid && m_q.size() > 0) begin
            e = m_q.pop_front();
            m_wen = (e.rd != 0); m_rd = e.rd; m_data = m_ext(e.f3, e.off, bus.mem_rsp_data);
            if (acc) begin m_skv = 1; m_skrd = bus.ex_rd; m_skdata = bus.ex_result; end
        end else begin
            if (bus.mem_rsp_valid) m_err = 1;
            if (m_skv) begin
                m_wen = (m_skrd != 0); m_rd = m_skrd; m_data = m_skdata; m_skv = 0;
            end else if (acc) begin
                m_wen = (bus.ex_rd != 0); m_rd = bus.ex_rd; m_data = bus.ex_result;
            end
        end
        if (push) begin
            e.rd = bus.ld_rd; e.f3 = bus.ld_funct3; e.off = bus.ld_offset;
            m_q.push_back(e);
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    task automatic cyc();
        @(negedge clk);
        chk("ex_ready",   32'(bus.ex_ready),   32'(m_ex_ready()));
        chk("ld_ready",   32'(bus.ld_ready),   32'(!rst && m_q.size() < DEPTH));
        chk("hazard",     32'(bus.hazard),     32'(pending(bus.rs1) || pending(bus.rs2)));
        chk("lq_count",   32'(bus.lq_count),   32'(m_q.size()));
        chk("err_orphan", 32'(bus.err_orphan), 32'(m_err));
        chk("rf_w_en",    32'(bus.rf_w_en),    32'(m_wen));
        if (m_wen) begin
            chk("rf_rd",     32'(bus.rf_rd), m_rd);
            chk("rf_data_w", bus.rf_data_w,  m_data);
        end
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        #1;
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_result = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_funct3 = 0; bus.ld_offset = 0;
        bus.mem_rsp_valid = 0; bus.mem_rsp_data = 0;
        bus.rs1 = 0; bus.rs2 = 0;
    endtask

    task automatic issue(input int unsigned rd, input int unsigned f3, input int unsigned off);
        bus.ld_valid = 1; bus.ld_rd = 5'(rd); bus.ld_funct3 = 3'(f3); bus.ld_offset = 2'(off);
        cyc();
        bus.ld_valid = 0;
    endtask

    task automatic chk_write(input string tag, input int unsigned rd, input logic [31:0] data);
        chk({tag, ".w_en"}, 32'(bus.rf_w_en), 32'd1);
        chk({tag, ".rd"},   32'(bus.rf_rd),   rd);
        chk({tag, ".data"}, bus.rf_data_w,    data);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".w_en"},  32'(bus.rf_w_en),    32'd0);
        chk({tag, ".rd"},    32'(bus.rf_rd),      32'd0);
        chk({tag, ".data"},  bus.rf_data_w,       32'd0);
        chk({tag, ".count"}, 32'(bus.lq_count),   32'd0);
        chk({tag, ".err"},   32'(bus.err_orphan), 32'd0);
        chk({tag, ".exr"},   32'(bus.ex_ready),   32'd0);
        chk({tag, ".ldr"},   32'(bus.ld_ready),   32'd0);
    endtask

    initial begin
        nchk = 0; nfail = 0;
        idle();
        rst = 1;
        m_reset();
        #1;
        chk_zero("reset");
        cyc(); cyc();
        rst = 0;
        #1;

        // ALU only, single-cycle write pulse
        bus.ex_valid = 1; bus.ex_rd = 5; bus.ex_result = 32'h1234;
        cyc();
        idle();
        chk_write("alu", 5, 32'h1234);
        cyc();
        chk("alu.pulse", 32'(bus.rf_w_en), 32'd0);

        // LB offset 3 and LHU offset 2 on the same word
        issue(7, 0, 3);
        chk("lb.count", 32'(bus.lq_count), 32'd1);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h80FF_0000;
        cyc();
        bus.mem_rsp_valid = 0;
        chk_write("lb", 7, 32'hFFFF_FF80);
        issue(10, 5, 2);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h80FF_0000;
        cyc();
        bus.mem_rsp_valid = 0;
        chk_write("lhu", 10, 32'h0000_80FF);

        // Response vs ALU collision: ALU goes through the skid
        issue(3, 2, 0);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hAAAA_AAAA;
        bus.ex_valid = 1; bus.ex_rd = 4; bus.ex_result = 32'h55;
        cyc();
        idle();
        #1;
        chk_write("coll.ld", 3, 32'hAAAA_AAAA);
        chk("coll.exr_lo", 32'(bus.ex_ready), 32'd0);
        cyc();
        chk_write("coll.alu", 4, 32'h55);
        chk("coll.exr_hi", 32'(bus.ex_ready), 32'd1);

        // Back-to-back responses keep the skid waiting
        issue(11, 1, 0);
        issue(12, 4, 1);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h1234_F00D;
        bus.ex_valid = 1; bus.ex_rd = 13; bus.ex_result = 32'h77;
        cyc();
        bus.ex_valid = 0; bus.mem_rsp_data = 32'h0000_AB00;
        chk_write("lh", 11, 32'hFFFF_F00D);
        cyc();
        idle();
        chk_write("lbu", 12, 32'h0000_00AB);
        cyc();
        chk_write("skid", 13, 32'h77);

        // Queue full, WAW stall, RAW hazard
        issue(8, 2, 0);
        issue(9, 2, 0);
        chk("full.ldr", 32'(bus.ld_ready), 32'd0);
        chk("full.count", 32'(bus.lq_count), 32'd2);
        bus.ex_valid = 1; bus.ex_rd = 9; bus.ex_result = 32'h99; bus.rs1 = 8;
        #1;
        chk("waw.exr", 32'(bus.ex_ready), 32'd0);
        chk("raw.hz", 32'(bus.hazard), 32'd1);
        cyc();
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h11;
        cyc();
        bus.mem_rsp_data = 32'h22;
        #1;
        chk_write("waw.r8", 8, 32'h11);
        chk("raw.hz_wr", 32'(bus.hazard), 32'd1);
        chk("waw.exr2", 32'(bus.ex_ready), 32'd0);
        cyc();
        bus.mem_rsp_valid = 0;
        #1;
        chk_write("waw.r9", 9, 32'h22);
        chk("waw.exr3", 32'(bus.ex_ready), 32'd1);
        chk("raw.hz_clr", 32'(bus.hazard), 32'd0);
        cyc();
        idle();
        chk_write("waw.alu", 9, 32'h99);

        // rd=0 load and orphan response
        issue(0, 2, 0);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hDEAD_BEEF;
        cyc();
        chk("rd0.w_en", 32'(bus.rf_w_en), 32'd0);
        chk("rd0.count", 32'(bus.lq_count), 32'd0);
        cyc();
        bus.mem_rsp_valid = 0;
        chk("orphan.err", 32'(bus.err_orphan), 32'd1);
        chk("orphan.w_en", 32'(bus.rf_w_en), 32'd0);
        cyc();

        // Reset with a load outstanding and the skid full
        issue(12, 2, 0);
        issue(13, 2, 0);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h5;
        bus.ex_valid = 1; bus.ex_rd = 14; bus.ex_result = 32'hE;
        cyc();
        idle();
        chk("pre_rst.count", 32'(bus.lq_count), 32'd1);
        rst = 1;
        m_reset();
        #1;
        chk_zero("midrst");
        cyc(); cyc();
        rst = 0;
        #1;
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h6;
        cyc();
        idle();
        chk("post_rst.err", 32'(bus.err_orphan), 32'd1);
        chk("post_rst.w_en", 32'(bus.rf_w_en), 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
